// File: rtl/color_event_filter.sv
// Debounces the sensor colour code, emits one valid/ready event per colour patch,
// lights the matching LED for a fixed time and keeps saturating per-colour counts.
module color_event_filter #(
  parameter int STABLE_CYCLES = 1000,
  parameter int CLEAR_CYCLES  = 1000,
  parameter int LED_HOLD      = 300000,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       color_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_color,
  output logic             led_r,
  output logic             led_g,
  output logic             led_b,
  output logic [CNT_W-1:0] red_count,
  output logic [CNT_W-1:0] green_count,
  output logic [CNT_W-1:0] blue_count
);

  localparam int STAB_W = $clog2(STABLE_CYCLES);
  localparam int CLR_W  = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam int LED_W  = (LED_HOLD > 1) ? $clog2(LED_HOLD) : 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [CLR_W-1:0]  CLR_LAST  = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [LED_W-1:0]  LED_LAST  = LED_W'(LED_HOLD - 1);

  typedef enum logic [1:0] {IDLE, QUALIFY, REPORT, HOLD_OFF} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        col_q_reg;
  logic [1:0]        cand_reg, cand_next;
  logic [STAB_W-1:0] stab_cnt_reg, stab_cnt_next;
  logic [CLR_W-1:0]  clr_cnt_reg, clr_cnt_next;
  logic              evt_valid_reg, evt_valid_next;
  logic [1:0]        evt_color_reg, evt_color_next;
  logic [LED_W-1:0]  led_timer_reg, led_timer_next;
  logic [2:0]        led_reg, led_next;
  logic              gen_evt;
  logic [CNT_W-1:0]  count_w [3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      col_q_reg     <= 2'd0;
      cand_reg      <= 2'd0;
      stab_cnt_reg  <= '0;
      clr_cnt_reg   <= '0;
      evt_valid_reg <= 1'b0;
      evt_color_reg <= 2'd0;
      led_timer_reg <= '0;
      led_reg       <= 3'b000;
    end else begin
      state_reg     <= state_next;
      // Codes 4..7 are not colours and are folded to "none".
      col_q_reg     <= color_in[2] ? 2'd0 : color_in[1:0];
      cand_reg      <= cand_next;
      stab_cnt_reg  <= stab_cnt_next;
      clr_cnt_reg   <= clr_cnt_next;
      evt_valid_reg <= evt_valid_next;
      evt_color_reg <= evt_color_next;
      led_timer_reg <= led_timer_next;
      led_reg       <= led_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cand_next      = cand_reg;
    stab_cnt_next  = stab_cnt_reg;
    clr_cnt_next   = clr_cnt_reg;
    evt_valid_next = evt_valid_reg;
    evt_color_next = evt_color_reg;
    gen_evt        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (col_q_reg != 2'd0) begin
          cand_next     = col_q_reg;
          stab_cnt_next = STAB_W'(1);
          state_next    = QUALIFY;
        end
      end
      QUALIFY: begin
        if (col_q_reg == 2'd0) begin
          stab_cnt_next = '0;
          state_next    = IDLE;
        end else if (col_q_reg != cand_reg) begin
          cand_next     = col_q_reg;
          stab_cnt_next = STAB_W'(1);
        end else if (stab_cnt_reg == STAB_LAST) begin
          gen_evt        = 1'b1;
          evt_valid_next = 1'b1;
          evt_color_next = cand_reg;
          state_next     = REPORT;
        end else begin
          stab_cnt_next = stab_cnt_reg + 1'b1;
        end
      end
      REPORT: begin
        if (evt_valid_reg && evt_ready) begin
          evt_valid_next = 1'b0;
          clr_cnt_next   = '0;
          state_next     = HOLD_OFF;
        end
      end
      HOLD_OFF: begin
        // Any colour seen restarts the clear window, so a held patch never re-fires.
        if (col_q_reg != 2'd0) begin
          clr_cnt_next = '0;
        end else if (clr_cnt_reg == CLR_LAST) begin
          state_next = IDLE;
        end else begin
          clr_cnt_next = clr_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    led_timer_next = led_timer_reg;
    led_next       = led_reg;
    if (gen_evt) begin
      led_timer_next = LED_LAST;
      led_next       = 3'b000;
      led_next[cand_reg - 2'd1] = 1'b1;
    end else if (led_timer_reg != '0) begin
      led_timer_next = led_timer_reg - 1'b1;
    end else begin
      led_next = 3'b000;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_count
      logic [CNT_W-1:0] count_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          count_reg <= '0;
        end else if (gen_evt && cand_reg == 2'(gi + 1) && count_reg != '1) begin
          count_reg <= count_reg + 1'b1;
        end
      end
      assign count_w[gi] = count_reg;
    end
  endgenerate

  assign evt_valid   = evt_valid_reg;
  assign evt_color   = evt_color_reg;
  assign led_r       = led_reg[0];
  assign led_g       = led_reg[1];
  assign led_b       = led_reg[2];
  assign red_count   = count_w[0];
  assign green_count = count_w[1];
  assign blue_count  = count_w[2];

endmodule

// File: tb/tb_color_event_filter.sv
// Scoreboarded bench for color_event_filter: expected events are queued as stimulus
// is driven and checked when the consumer accepts them.
module tb_color_event_filter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] color_in = 3'd0;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [1:0] evt_color;
  logic       led_r, led_g, led_b;
  logic [1:0] red_count, green_count, blue_count;

  color_event_filter #(
    .STABLE_CYCLES(4),
    .CLEAR_CYCLES (3),
    .LED_HOLD     (10),
    .CNT_W        (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .color_in   (color_in),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_color  (evt_color),
    .led_r      (led_r),
    .led_g      (led_g),
    .led_b      (led_b),
    .red_count  (red_count),
    .green_count(green_count),
    .blue_count (blue_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] color;
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [1:0] exp_r = 2'd0, exp_g = 2'd0, exp_b = 2'd0;
  int         n_checks = 0;
  int         n_fail   = 0;

  // Reference model: saturating counts at 3 for a 2-bit counter.
  function automatic void push_evt(input logic [1:0] c);
    exp_t e;
    if (c == 2'd1 && exp_r != 2'd3) exp_r = exp_r + 2'd1;
    if (c == 2'd2 && exp_g != 2'd3) exp_g = exp_g + 2'd1;
    if (c == 2'd3 && exp_b != 2'd3) exp_b = exp_b + 2'd1;
    e.color = c; e.r = exp_r; e.g = exp_g; e.b = exp_b;
    exp_q.push_back(e);
  endfunction

  function automatic void clear_model();
    exp_r = 2'd0; exp_g = 2'd0; exp_b = 2'd0;
    exp_q.delete();
  endfunction

  task automatic step(input logic [2:0] c);
    color_in = c;
    @(posedge clk);
    #1;
  endtask

  // Accepted events are compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got colour %0d at %0t, required no event", evt_color, $time);
      end else begin
        mon_e = exp_q.pop_front();
        if ({evt_color, red_count, green_count, blue_count} !== {mon_e.color, mon_e.r, mon_e.g, mon_e.b}) begin
          n_fail++;
          $display("FAIL event_accept: got colour %0d counts r%0d g%0d b%0d, required colour %0d counts r%0d g%0d b%0d",
                   evt_color, red_count, green_count, blue_count, mon_e.color, mon_e.r, mon_e.g, mon_e.b);
        end
      end
      $display("event accepted: colour %0d counts r%0d g%0d b%0d at %0t", evt_color, red_count, green_count, blue_count, $time);
    end
  end

  task automatic test_reset();
    evt_ready = 1'b0;
    color_in  = 3'd0;
    #1 rst = 1'b1;
    #2;
    n_checks++;
    if ({evt_valid, evt_color, led_r, led_g, led_b, red_count, green_count, blue_count} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_async: got %b, required all zero",
               {evt_valid, evt_color, led_r, led_g, led_b, red_count, green_count, blue_count});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step(3'd0);
    n_checks++;
    if ({evt_valid, evt_color, led_r, led_g, led_b, red_count, green_count, blue_count} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_release: got %b, required all zero",
               {evt_valid, evt_color, led_r, led_g, led_b, red_count, green_count, blue_count});
    end
  endtask

  task automatic test_basic();
    evt_ready = 1'b1;
    push_evt(2'd1);
    for (int i = 1; i <= 4; i++) begin
      step(3'd1);
      n_checks++;
      if (evt_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_early edge %0d: evt_valid %b, required 0", i, evt_valid);
      end
    end
    step(3'd1);
    n_checks++;
    if ({evt_valid, evt_color, red_count, led_b, led_g, led_r} !== {1'b1, 2'd1, 2'd1, 3'b001}) begin
      n_fail++;
      $display("FAIL basic_event: valid %b colour %0d red %0d leds %b, required 1 1 1 001",
               evt_valid, evt_color, red_count, {led_b, led_g, led_r});
    end
    step(3'd1);
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_one_cycle: evt_valid %b, required 0", evt_valid);
    end
    repeat (8) step(3'd1);
    n_checks++;
    if ({led_b, led_g, led_r} !== 3'b001) begin
      n_fail++;
      $display("FAIL basic_led_last: leds %b, required 001", {led_b, led_g, led_r});
    end
    step(3'd1);
    n_checks++;
    if ({led_b, led_g, led_r} !== 3'b000) begin
      n_fail++;
      $display("FAIL basic_led_off: leds %b, required 000", {led_b, led_g, led_r});
    end
    for (int i = 0; i < 10; i++) begin
      step(3'd1);
      n_checks++;
      if (evt_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_retrigger cycle %0d: evt_valid %b, required 0", i, evt_valid);
      end
    end
    repeat (5) step(3'd0);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_drain: %0d events outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_glitch();
    evt_ready = 1'b1;
    repeat (3) step(3'd2);
    repeat (3) step(3'd0);
    n_checks++;
    if ({evt_valid, red_count, green_count, blue_count} !== {1'b0, 2'd1, 2'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL glitch_short: valid %b counts r%0d g%0d b%0d, required 0 r1 g0 b0",
               evt_valid, red_count, green_count, blue_count);
    end
    push_evt(2'd3);
    repeat (2) step(3'd2);
    repeat (8) step(3'd3);
    repeat (5) step(3'd0);
    n_checks++;
    if ({green_count, blue_count} !== {2'd0, 2'd1} || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL glitch_switch: g%0d b%0d outstanding %0d, required g0 b1 outstanding 0",
               green_count, blue_count, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    evt_ready = 1'b0;
    push_evt(2'd3);
    repeat (6) step(3'd3);
    for (int i = 0; i < 20; i++) begin
      step(3'($urandom_range(0, 7)));
      n_checks++;
      if ({evt_valid, evt_color} !== {1'b1, 2'd3}) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: valid %b colour %0d, required 1 3", i, evt_valid, evt_color);
      end
    end
    color_in  = 3'd0;
    evt_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: evt_valid %b, required 0", evt_valid);
    end
    repeat (5) step(3'd0);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_drain: %0d events outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_rearm();
    logic [2:0] seq [10];
    seq = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1};
    evt_ready = 1'b1;
    push_evt(2'd1);
    repeat (6) step(3'd1);
    push_evt(2'd1);
    for (int i = 0; i < 10; i++) begin
      step(seq[i]);
      n_checks++;
      if (evt_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rearm_early step %0d: evt_valid %b, required 0", i, evt_valid);
      end
    end
    step(3'd0);
    n_checks++;
    if ({evt_valid, evt_color, red_count} !== {1'b1, 2'd1, exp_r}) begin
      n_fail++;
      $display("FAIL rearm_event: valid %b colour %0d red %0d, required 1 1 %0d",
               evt_valid, evt_color, red_count, exp_r);
    end
    repeat (5) step(3'd0);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rearm_drain: %0d events outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    evt_ready = 1'b0;
    repeat (6) step(3'd1);
    n_checks++;
    if ({evt_valid, led_r} !== 2'b11) begin
      n_fail++;
      $display("FAIL ar_pending: valid %b led_r %b, required 1 1", evt_valid, led_r);
    end
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({evt_valid, led_r, led_g, led_b, red_count, green_count, blue_count} !== 10'd0) begin
      n_fail++;
      $display("FAIL ar_report: got %b, required all zero",
               {evt_valid, led_r, led_g, led_b, red_count, green_count, blue_count});
    end
    clear_model();
    color_in = 3'd0;
    @(posedge clk);
    #1 rst = 1'b0;
    evt_ready = 1'b1;
    push_evt(2'd2);
    repeat (6) step(3'd2);
    n_checks++;
    if ({led_g, green_count, evt_valid} !== {1'b1, 2'd1, 1'b0} || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL ar_after: led_g %b green %0d valid %b outstanding %0d, required 1 1 0 0",
               led_g, green_count, evt_valid, exp_q.size());
    end
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({evt_valid, led_r, led_g, led_b, red_count, green_count, blue_count} !== 10'd0) begin
      n_fail++;
      $display("FAIL ar_led: got %b, required all zero",
               {evt_valid, led_r, led_g, led_b, red_count, green_count, blue_count});
    end
    clear_model();
    color_in = 3'd0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) step(3'd0);
  endtask

  task automatic test_saturation();
    logic [1:0] sat_tab [5];
    sat_tab = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    evt_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_evt(2'd1);
      repeat (6) step(3'd1);
      n_checks++;
      if (red_count !== sat_tab[i]) begin
        n_fail++;
        $display("FAIL saturation event %0d: red_count %0d, required %0d", i, red_count, sat_tab[i]);
      end
      repeat (5) step(3'd0);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sat_drain: %0d events outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_backpressure();
    test_rearm();
    test_async_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
